// File: rtl/cop_ram_spi_master_pkg.sv
// cop_ram_spi_master_pkg: states, RAM opcodes and core-logic codes shared across the coprocessor SPI path
package cop_ram_spi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_OPCODE,
        ST_CMD,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_DATA,
        ST_DESELECT
    } state_t;

    localparam logic [7:0] RAM_CMD_READ      = 8'h03;
    localparam logic [7:0] RAM_CMD_WRITE     = 8'h02;

    localparam logic [2:0] COP_SEL_NONE      = 3'd0;
    localparam logic [2:0] COP_SEL_LOGIC     = 3'd1;
    localparam logic [7:0] COP_OP_ACCESS_RAM = 8'h02;

endpackage

// File: rtl/cop_ram_spi_master_shifter.sv
// spi_byte_shifter: one mode-0 SPI byte, 16 half-periods of CLK_DIV clocks, either bit order
module spi_byte_shifter #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       lsb_first,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sck,
    output logic       mosi,
    output logic       active,
    output logic       done,
    output logic       rx_done,
    output logic [7:0] rx_byte
);
    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] div;
    logic [3:0]    half;
    logic [7:0]    sr;
    logic          lsb;
    logic          tick;

    assign tick = active && div == CW'(CLK_DIV - 1);
    // done is high in the cycle before the 8th falling edge so a new byte can start on that edge
    assign done = tick && sck && half == 4'd15;

    // divider, SCK toggling, MOSI launch on falling edges and MISO capture on rising edges
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div     <= '0;
            half    <= '0;
            sr      <= '0;
            lsb     <= 1'b0;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            active  <= 1'b0;
            rx_done <= 1'b0;
            rx_byte <= '0;
        end else begin
            rx_done <= 1'b0;
            if (start) begin
                active <= 1'b1;
                div    <= '0;
                half   <= '0;
                sck    <= 1'b0;
                sr     <= tx_byte;
                lsb    <= lsb_first;
                mosi   <= lsb_first ? tx_byte[0] : tx_byte[7];
            end else if (tick) begin
                div  <= '0;
                half <= half + 4'd1;
                sck  <= ~sck;
                if (!sck) begin
                    rx_byte <= lsb ? {miso, rx_byte[7:1]} : {rx_byte[6:0], miso};
                    rx_done <= half == 4'd14;
                end else begin
                    sr     <= lsb ? sr >> 1 : sr << 1;
                    mosi   <= lsb ? sr[1] : sr[6];
                    active <= half != 4'd15;
                end
            end else if (active) begin
                div <= div + CW'(1);
            end
        end
    end

endmodule

// File: rtl/cop_ram_spi_master.sv
// cop_ram_spi_master: turns a parallel RAM request into one SPI session through the core logic
module cop_ram_spi_master
    import cop_ram_spi_master_pkg::*;
#(
    parameter int                   CLK_DIV       = 4,
    parameter int                   SEL_WIDTH     = 3,
    parameter logic [SEL_WIDTH-1:0] SEL_LOGIC     = SEL_WIDTH'(COP_SEL_LOGIC),
    parameter logic [SEL_WIDTH-1:0] SEL_NONE      = SEL_WIDTH'(COP_SEL_NONE),
    parameter logic [7:0]           OP_ACCESS_RAM = COP_OP_ACCESS_RAM
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [15:0]          req_addr,
    input  logic [7:0]           req_len,
    input  logic [7:0]           wr_data,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    output logic [7:0]           rd_data,
    output logic                 rd_valid,
    output logic                 busy,
    output logic [SEL_WIDTH-1:0] cop_select,
    output logic                 cop_sck,
    output logic                 cop_mosi,
    input  logic                 cop_miso
);
    localparam int TW = $clog2(2 * CLK_DIV);

    state_t        state, state_d;
    logic [15:0]   addr_q;
    logic [7:0]    len_q;
    logic [7:0]    cnt;
    logic          wr_q;
    logic [TW-1:0] tmr;
    logic          sh_start, sh_lsb, sh_active, sh_done, sh_rx_done;
    logic [7:0]    sh_tx, sh_rx;
    logic          take, cnt_inc, rd_take;

    assign req_ready = state == ST_IDLE;
    assign busy      = state != ST_IDLE;
    assign rd_take   = sh_rx_done && state == ST_DATA && !wr_q;

    spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .start     (sh_start),
        .lsb_first (sh_lsb),
        .tx_byte   (sh_tx),
        .miso      (cop_miso),
        .sck       (cop_sck),
        .mosi      (cop_mosi),
        .active    (sh_active),
        .done      (sh_done),
        .rx_done   (sh_rx_done),
        .rx_byte   (sh_rx)
    );

    // session state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_d;
    end

    // next state plus byte launches; each header byte starts on the final edge of the previous one
    always_comb begin
        state_d  = state;
        sh_start = 1'b0;
        sh_lsb   = 1'b0;
        sh_tx    = '0;
        take     = 1'b0;
        cnt_inc  = 1'b0;
        case (state)
            ST_IDLE:     if (req_valid) state_d = ST_SELECT;
            ST_SELECT: begin
                if (tmr == TW'(CLK_DIV - 1)) begin
                    state_d  = ST_OPCODE;
                    sh_start = 1'b1;
                    sh_lsb   = 1'b1;
                    sh_tx    = OP_ACCESS_RAM;
                end
            end
            ST_OPCODE: begin
                if (sh_done) begin
                    state_d  = ST_CMD;
                    sh_start = 1'b1;
                    sh_tx    = wr_q ? RAM_CMD_WRITE : RAM_CMD_READ;
                end
            end
            ST_CMD: begin
                if (sh_done) begin
                    state_d  = ST_ADDR_HI;
                    sh_start = 1'b1;
                    sh_tx    = addr_q[15:8];
                end
            end
            ST_ADDR_HI: begin
                if (sh_done) begin
                    state_d  = ST_ADDR_LO;
                    sh_start = 1'b1;
                    sh_tx    = addr_q[7:0];
                end
            end
            ST_ADDR_LO: begin
                if (sh_done) begin
                    state_d  = ST_DATA;
                    sh_start = !wr_q;
                end
            end
            ST_DATA: begin
                if (sh_done) begin
                    state_d  = cnt == len_q ? ST_DESELECT : ST_DATA;
                    cnt_inc  = cnt != len_q;
                    sh_start = cnt != len_q && !wr_q;
                end else if (wr_q && !sh_active && wr_valid) begin
                    take     = 1'b1;
                    sh_start = 1'b1;
                    sh_tx    = wr_data;
                end
            end
            ST_DESELECT: if (tmr == TW'(2 * CLK_DIV - 1)) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // request latch, byte counter, phase timer and registered handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            len_q      <= '0;
            wr_q       <= 1'b0;
            cnt        <= '0;
            tmr        <= '0;
            cop_select <= SEL_NONE;
            wr_ready   <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
        end else begin
            if (state == ST_IDLE && req_valid) begin
                addr_q <= req_addr;
                len_q  <= req_len;
                wr_q   <= req_write;
            end
            cnt        <= state == ST_IDLE ? 8'd0 : cnt + 8'(cnt_inc);
            tmr        <= state_d != state ? '0 : tmr + TW'(1);
            cop_select <= (state_d == ST_IDLE || state_d == ST_DESELECT) ? SEL_NONE : SEL_LOGIC;
            wr_ready   <= take;
            rd_valid   <= rd_take;
            if (rd_take) rd_data <= sh_rx;
        end
    end

endmodule

// File: tb/tb_cop_ram_spi_master.sv
// tb_cop_ram_spi_master: directed sessions against an SPI slave model with a small serial RAM
module tb_cop_ram_spi_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_len = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        cop_miso;
    logic        req_ready, wr_ready, rd_valid, busy, cop_sck, cop_mosi;
    logic [7:0]  rd_data;
    logic [2:0]  cop_select;

    int          checks = 0;
    int          errors = 0;
    logic        bits [0:4095];
    int          nbits = 0;
    logic [7:0]  rxb [0:511];
    int          nrx = 0;
    int          nwr = 0;
    logic [7:0]  ram [0:255];
    int          base = 0;
    int          rx0 = 0;
    int          wr0 = 0;

    cop_ram_spi_master dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .busy       (busy),
        .cop_select (cop_select),
        .cop_sck    (cop_sck),
        .cop_mosi   (cop_mosi),
        .cop_miso   (cop_miso)
    );

    always #5 clk = ~clk;

    // slave side: record MOSI on every rising SCK while the core logic is selected
    always @(posedge cop_sck) begin
        if (cop_select == 3'd1) begin
            bits[nbits[11:0]] <= cop_mosi;
            nbits <= nbits + 1;
        end
    end

    // RAM returns data MSB-first once the 32 header bits have gone by
    always_comb begin
        int k;
        k = nbits - base - 32;
        cop_miso = (k >= 0 && k < 2048) ? ram[k[10:3]][3'd7 - k[2:0]] : 1'b0;
    end

    always @(negedge clk) begin
        if (rd_valid) begin
            rxb[nrx[8:0]] <= rd_data;
            nrx <= nrx + 1;
        end
        if (wr_ready) nwr <= nwr + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mbyte(input int i);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[i == 0 ? k : 7 - k] = bits[base + 8 * i + k];
        return b;
    endfunction

    task automatic start_req(input logic w, input logic [15:0] a, input logic [7:0] l);
        @(negedge clk);
        base = nbits;
        rx0 = nrx;
        wr0 = nwr;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_write = w;
        req_addr = a;
        req_len = l;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr = 16'hFFFF;
        req_len = 8'hFF;
        req_write = ~w;
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic feed_byte(input logic [7:0] b);
        int i = 0;
        wr_data = b;
        wr_valid = 1'b1;
        while (!wr_ready && i < 2000) begin
            @(negedge clk);
            i++;
        end
        wr_valid = 1'b0;
        check("wr_ready_seen", 32'(wr_ready), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int i = 0;
        while (busy && i < 20000) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_bits(input int n, input string tag);
        int i = 0;
        while (nbits - base < n && i < 5000) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(nbits - base >= n), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int n0;
        int bad;
        for (int j = 0; j < 256; j++) ram[j] = 8'h00;
        ram[0] = 8'h11;
        ram[1] = 8'h22;
        ram[2] = 8'h33;
        ram[3] = 8'h44;
        #12;
        check("rst_select", 32'(cop_select), 32'd0);
        check("rst_sck", 32'(cop_sck), 32'd0);
        check("rst_mosi", 32'(cop_mosi), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // single-byte write to 0x1234
        start_req(1'b1, 16'h1234, 8'd0);
        feed_byte(8'hA5);
        wait_idle("w1_idle");
        check("w1_sck_periods", nbits - base, 32'd40);
        check("w1_opcode", 32'(mbyte(0)), 32'h02);
        check("w1_cmd", 32'(mbyte(1)), 32'h02);
        check("w1_addr_hi", 32'(mbyte(2)), 32'h12);
        check("w1_addr_lo", 32'(mbyte(3)), 32'h34);
        check("w1_data", 32'(mbyte(4)), 32'hA5);
        check("w1_wr_pulses", nwr - wr0, 32'd1);
        check("w1_deselect", 32'(cop_select), 32'd0);

        // four-byte read from 0x0010
        start_req(1'b0, 16'h0010, 8'd3);
        wait_idle("r4_idle");
        check("r4_count", nrx - rx0, 32'd4);
        check("r4_byte0", 32'(rxb[rx0]), 32'h11);
        check("r4_byte1", 32'(rxb[rx0 + 1]), 32'h22);
        check("r4_byte2", 32'(rxb[rx0 + 2]), 32'h33);
        check("r4_byte3", 32'(rxb[rx0 + 3]), 32'h44);
        check("r4_cmd", 32'(mbyte(1)), 32'h03);
        check("r4_addr_hi", 32'(mbyte(2)), 32'h00);
        check("r4_addr_lo", 32'(mbyte(3)), 32'h10);
        check("r4_mosi_zero", 32'(mbyte(5)), 32'h00);
        check("r4_no_wr_ready", nwr - wr0, 32'd0);
        check("r4_sck_periods", nbits - base, 32'd64);

        // two-byte write with a 50-cycle stall before the second byte
        start_req(1'b1, 16'hBEEF, 8'd1);
        feed_byte(8'hC3);
        wait_bits(40, "st_byte1_done");
        hi = 0;
        while (cop_sck && hi < 100) begin
            @(negedge clk);
            hi++;
        end
        hi = 0;
        n0 = nbits;
        repeat (50) begin
            @(negedge clk);
            if (cop_sck) hi++;
        end
        check("st_sck_low", hi, 32'd0);
        check("st_no_bits", nbits - n0, 32'd0);
        check("st_still_busy", 32'(busy), 32'd1);
        feed_byte(8'h5E);
        wait_idle("st_idle");
        check("st_addr_hi", 32'(mbyte(2)), 32'hBE);
        check("st_addr_lo", 32'(mbyte(3)), 32'hEF);
        check("st_byte1", 32'(mbyte(4)), 32'hC3);
        check("st_byte2", 32'(mbyte(5)), 32'h5E);
        check("st_bits", nbits - base, 32'd48);
        check("st_wr_pulses", nwr - wr0, 32'd2);

        // 256-byte read, counter must run the full range
        for (int j = 0; j < 256; j++) ram[j] = 8'(j) ^ 8'h5A;
        start_req(1'b0, 16'h8000, 8'd255);
        wait_idle("r256_idle");
        check("r256_count", nrx - rx0, 32'd256);
        bad = 0;
        for (int j = 0; j < 256; j++) if (rxb[rx0 + j] !== (8'(j) ^ 8'h5A)) bad++;
        check("r256_data", bad, 32'd0);
        check("r256_last", 32'(rxb[rx0 + 255]), 32'hA5);

        // reset in the middle of ADDR_HI, then a normal session
        start_req(1'b1, 16'h4321, 8'd0);
        wait_bits(18, "rst_reach_addr_hi");
        #2 reset = 1'b1;
        #1;
        check("mid_rst_select", 32'(cop_select), 32'd0);
        check("mid_rst_sck", 32'(cop_sck), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        start_req(1'b1, 16'h00FF, 8'd0);
        feed_byte(8'h3C);
        wait_idle("post_rst_idle");
        check("post_rst_bits", nbits - base, 32'd40);
        check("post_rst_opcode", 32'(mbyte(0)), 32'h02);
        check("post_rst_addr_lo", 32'(mbyte(3)), 32'hFF);
        check("post_rst_data", 32'(mbyte(4)), 32'h3C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
